btn_conditioner: RTL
====================

# btn_conditioner

Parametrised multi-channel push-button conditioner for the stopwatch front panel. It sits between the raw board buttons and the control FSM, and for every channel provides:
- synchronisation and optional polarity inversion;
- exact-count debouncing;
- one-cycle press and release strobes;
- long-press detection with auto-repeat.

It replaces the fixed 4-channel, level-only debouncer so the control logic no longer builds its own edge detectors or hold timers.

## Interface
Parameters:
- N, 4: number of independent button channels (≥1).
- DEBOUNCE_CYCLES, 1048576: consecutive stable cycles required before BTN_clean changes (≥1).
- HOLD_CYCLES, 50000000: cycles BTN_clean must stay high after a press before BTN_hold asserts. 0 disables both hold and repeat.
- REPEAT_CYCLES, 10000000: auto-repeat period while held. 0 disables repeat.
- ACTIVE_LOW, 0: 1 inverts BTN after synchronisation, so a pressed button reads as 1 internally.

Ports:
- CLK  in  1  system clock; everything in the block is on its rising edge.
- RST  in  1  synchronous, active-high reset.
- BTN  in  N  raw asynchronous button inputs.
- BTN_clean  out  N  debounced level, 1 = pressed.
- BTN_press  out  N  one-cycle strobe on each 0→1 of BTN_clean.
- BTN_release  out  N  one-cycle strobe on each 1→0 of BTN_clean.
- BTN_hold  out  N  level, high while a long press is in progress.
- BTN_repeat  out  N  one-cycle strobe when hold begins, then every REPEAT_CYCLES while held.

## Operation
Channels are fully independent and share no counters. Each channel contains the following stages.
- **Synchroniser:** two-flop chain sync0→sync1. The ACTIVE_LOW inversion is applied at sync1's output and gives the signal s.
- **Debounce counter:** width $clog2(DEBOUNCE_CYCLES+1).
  - If s == BTN_clean: the counter clears to 0.
  - Else, if counter == DEBOUNCE_CYCLES−1: BTN_clean ← s and the counter clears.
  - Else: the counter increments.
  - Any single cycle with s == BTN_clean restarts the count. The counter never wraps.
- **Edge strobes:**
  - BTN_press is registered high on the same edge BTN_clean goes 0→1.
  - BTN_release is registered high on the same edge BTN_clean goes 1→0.
  - Both are low in every other cycle.
- **Hold/repeat FSM,** with states IDLE, PRESSED, HOLDING:
  - IDLE→PRESSED on the press edge; hold counter cleared.
  - PRESSED: the hold counter increments each cycle. When it reaches HOLD_CYCLES−1, go to HOLDING, set BTN_hold=1, pulse BTN_repeat, and clear the repeat counter.
  - HOLDING: the repeat counter increments. At REPEAT_CYCLES−1 it pulses BTN_repeat and clears. Skip this if REPEAT_CYCLES=0.
  - Any state→IDLE on the release edge: BTN_hold←0 on that same edge, and the counters clear.
  - HOLD_CYCLES=0: the FSM stays in PRESSED and never asserts BTN_hold or BTN_repeat.
- **Reset (RST=1 on an edge):**
  - BTN_clean, BTN_press, BTN_release, BTN_hold and BTN_repeat go to 0.
  - All counters go to 0, the FSM goes to IDLE, and the sync flops go to the inactive level.
  - Reset mid-press or mid-hold aborts silently, with no release strobe.
  - A button still held after RST falls is re-debounced from zero.

## Timing
- Let e0 be the edge at which sync0 first captures a new stable BTN level. BTN_clean and the matching strobe update at edge e0+DEBOUNCE_CYCLES+1.
- A BTN pulse or glitch of DEBOUNCE_CYCLES−1 cycles or fewer produces no output change.
- First BTN_repeat (coincident with BTN_hold rising) occurs HOLD_CYCLES edges after the press strobe edge. Subsequent repeats follow every REPEAT_CYCLES edges.
- A release that coincides with a repeat or hold-entry edge takes priority: BTN_release=1, BTN_repeat=0, BTN_hold stays 0.
- Strobes are exactly one cycle wide. Press and release can never both be high in the same cycle on one channel.
- No combinational path from BTN to any output.

## Test plan
Parameters for all scenarios unless stated: N=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, ACTIVE_LOW=0.
- **Reset:** hold RST=1 for 3 cycles with BTN=2'b11 → every output is 0 throughout. After RST falls, BTN_clean[1:0]=11 with BTN_press=11 at edge e0+5.
- **Glitch rejection:** BTN[0] high for 3 cycles, then low → BTN_clean[0], BTN_press[0] and BTN_release[0] stay 0. A 4-cycle pulse → press at e0+5, release 4 cycles later.
- **Long press:** BTN[0] held 40 cycles → press strobe, then BTN_hold[0] and BTN_repeat[0] 10 cycles later, repeats every 3 cycles. On release, BTN_hold[0] falls on the BTN_release[0] edge.
- **Release on a repeat edge:** release BTN[0] so that the debounced release lands exactly on a scheduled repeat edge → BTN_release=1, BTN_repeat=0 on that edge.
- **Channel independence:** bounce BTN[1] (1-0-1-1-0-1-1-1-1) while BTN[0] is in HOLDING → channel 0 repeat cadence is unchanged. Channel 1 presses only after 4 stable cycles.
- **Mode variants:** ACTIVE_LOW=1 with BTN=2'b11 idle, driving 0 → press behaves as above. HOLD_CYCLES=0 → BTN_hold and BTN_repeat are never asserted.

Source files
------------

// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: synchroniser, exact-count debouncer,
// press/release strobes and long-press detection with auto-repeat per channel.
module btn_conditioner #(
    parameter int unsigned N               = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1048576,
    parameter int unsigned HOLD_CYCLES     = 50000000,
    parameter int unsigned REPEAT_CYCLES   = 10000000,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] BTN,
    output logic [N-1:0] BTN_clean,
    output logic [N-1:0] BTN_press,
    output logic [N-1:0] BTN_release,
    output logic [N-1:0] BTN_hold,
    output logic [N-1:0] BTN_repeat
);

    localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
    // Hold/repeat counters only ever reach CYCLES-1; keep at least one bit.
    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned RepW  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
    localparam logic [RepW-1:0]  RepLast  = RepW'(REPEAT_CYCLES - 1);
    localparam logic [N-1:0]     SyncIdle = {N{ACTIVE_LOW}};

    typedef enum logic [1:0] {StIdle, StPressed, StHolding} state_e;

    logic [N-1:0]     sync0_q, sync0_d, sync1_q, sync1_d;
    logic [N-1:0]     s;
    logic [N-1:0]     clean_q, clean_d;
    logic [N-1:0]     press_q, press_d, release_q, release_d;
    logic [N-1:0]     hold_q, hold_d, repeat_q, repeat_d;
    logic [N-1:0]     rise, fall;
    logic [DbW-1:0]   db_cnt_q   [N];
    logic [DbW-1:0]   db_cnt_d   [N];
    logic [HoldW-1:0] hold_cnt_q [N];
    logic [HoldW-1:0] hold_cnt_d [N];
    logic [RepW-1:0]  rep_cnt_q  [N];
    logic [RepW-1:0]  rep_cnt_d  [N];
    state_e           state_q    [N];
    state_e           state_d    [N];

    // Pressed level is 1 internally regardless of board polarity.
    assign s = sync1_q ^ SyncIdle;

    // Synchroniser chain and exact-count debouncer.
    always_comb begin
        sync0_d = BTN;
        sync1_d = sync0_q;
        clean_d = clean_q;
        for (int i = 0; i < int'(N); i++) begin
            db_cnt_d[i] = '0;
            if (s[i] != clean_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    clean_d[i] = s[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    assign rise = clean_d & ~clean_q;
    assign fall = ~clean_d & clean_q;

    // Edge strobes and hold/repeat FSM next-state; release overrides all.
    always_comb begin
        press_d   = rise;
        release_d = fall;
        hold_d    = hold_q;
        repeat_d  = '0;
        for (int i = 0; i < int'(N); i++) begin
            state_d[i]    = state_q[i];
            hold_cnt_d[i] = hold_cnt_q[i];
            rep_cnt_d[i]  = rep_cnt_q[i];
            case (state_q[i])
                StIdle: begin
                    if (rise[i]) begin
                        state_d[i]    = StPressed;
                        hold_cnt_d[i] = '0;
                    end
                end
                StPressed: begin
                    if (HOLD_CYCLES != 0) begin
                        if (hold_cnt_q[i] == HoldLast) begin
                            state_d[i]   = StHolding;
                            hold_d[i]    = 1'b1;
                            repeat_d[i]  = 1'b1;
                            rep_cnt_d[i] = '0;
                        end else begin
                            hold_cnt_d[i] = hold_cnt_q[i] + HoldW'(1);
                        end
                    end
                end
                StHolding: begin
                    if (REPEAT_CYCLES != 0) begin
                        if (rep_cnt_q[i] == RepLast) begin
                            repeat_d[i]  = 1'b1;
                            rep_cnt_d[i] = '0;
                        end else begin
                            rep_cnt_d[i] = rep_cnt_q[i] + RepW'(1);
                        end
                    end
                end
                default: state_d[i] = StIdle;
            endcase
            if (fall[i]) begin
                state_d[i]    = StIdle;
                hold_d[i]     = 1'b0;
                repeat_d[i]   = 1'b0;
                hold_cnt_d[i] = '0;
                rep_cnt_d[i]  = '0;
            end
        end
    end

    // State registers with synchronous reset; sync flops reset to the idle board level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync0_q   <= SyncIdle;
            sync1_q   <= SyncIdle;
            clean_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            hold_q    <= '0;
            repeat_q  <= '0;
            for (int i = 0; i < int'(N); i++) begin
                db_cnt_q[i]   <= '0;
                hold_cnt_q[i] <= '0;
                rep_cnt_q[i]  <= '0;
                state_q[i]    <= StIdle;
            end
        end else begin
            sync0_q   <= sync0_d;
            sync1_q   <= sync1_d;
            clean_q   <= clean_d;
            press_q   <= press_d;
            release_q <= release_d;
            hold_q    <= hold_d;
            repeat_q  <= repeat_d;
            for (int i = 0; i < int'(N); i++) begin
                db_cnt_q[i]   <= db_cnt_d[i];
                hold_cnt_q[i] <= hold_cnt_d[i];
                rep_cnt_q[i]  <= rep_cnt_d[i];
                state_q[i]    <= state_d[i];
            end
        end
    end

    assign BTN_clean   = clean_q;
    assign BTN_press   = press_q;
    assign BTN_release = release_q;
    assign BTN_hold    = hold_q;
    assign BTN_repeat  = repeat_q;

endmodule
